// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: access-type encodings, FSM state
// encodings and small byte-lane helpers used by the datapath.
package mem_ctrl_pkg;

    // Access width requested by the mem stage.
    typedef enum logic [1:0] {
        MT_NONE = 2'd0,
        MT_B    = 2'd1,
        MT_H    = 2'd2,
        MT_W    = 2'd3
    } mem_type_e;

    // Controller states; anything other than S_IDLE means busy.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA_RD = 2'd1,
        S_DATA_WR = 2'd2,
        S_IF_RD   = 2'd3
    } state_e;

    localparam logic [2:0] FETCH_BYTES = 3'd4;

    // Number of bytes moved for a data access of the given type.
    function automatic logic [2:0] type_bytes(input logic [1:0] t);
        logic [2:0] n;
        case (t)
            2'd1:    n = 3'd1;
            2'd2:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Little-endian byte lane k of a word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    // Word with byte lane k replaced by b.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_if_buffer.sv
// if_buffer: one-entry instruction fetch buffer (tag, word, valid).
// Only compiled when FETCH_BUF_EN is defined; the default build has no buffer.
`ifdef FETCH_BUF_EN
module if_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_addr_i,
    output logic        hit_o,
    output logic [31:0] word_o,
    input  logic        fill_i,
    input  logic [31:0] fill_addr_i,
    input  logic [31:0] fill_word_i,
    input  logic        inval_i,
    input  logic [31:0] inval_addr_i
);

    logic        valid_q;
    logic [31:0] tag_q;
    logic [31:0] word_q;
    logic [31:0] dist;

    // Modular distance so a tagged word straddling 0xFFFFFFFF still matches.
    assign dist   = inval_addr_i - tag_q;
    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign word_o = word_q;

    // Fill on every fetch completion; drop the entry when a written byte lands in it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            word_q  <= fill_word_i;
        end else if (inval_i && (dist < 32'd4)) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises data loads/stores and instruction fetches onto a
// byte-wide RAM with one cycle of read latency. Data requests win over
// fetches; accesses are never aborted. Define FETCH_BUF_EN to add a
// one-entry fetch buffer (module if_buffer).
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  mem_type_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic        data_done_o,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_done_o,
    output logic [31:0] ram_addr_o,
    output logic [7:0]  ram_dout_o,
    output logic        ram_wr_o,
    input  logic [7:0]  ram_din_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  nbytes_q;
    logic [2:0]  cnt_q;
    logic [31:0] scratch_q;
    logic [31:0] data_q;
    logic [31:0] inst_q;
    logic        hit_q;

    logic        data_req;
    logic        issue;
    logic        rd_last;
    logic        wr_last;
    logic        capture;
    logic [2:0]  cnt_m1;
    logic [2:0]  nbytes_m1;
    logic [31:0] merged;
    logic [31:0] if_word;
    logic        rd_done;
    logic        busy;
    logic        data_done;
    logic        if_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic        buf_hit;
    logic [31:0] buf_word;

    assign data_req  = (mem_read_i || mem_write_i) && (mem_type_i != MT_NONE);
    assign issue     = (cnt_q < nbytes_q);
    assign rd_last   = (cnt_q == nbytes_q);
    assign nbytes_m1 = nbytes_q - 3'd1;
    assign wr_last   = (cnt_q == nbytes_m1);
    assign cnt_m1    = cnt_q - 3'd1;
    // The last byte arrives in the done cycle, so fold it in combinationally.
    assign merged    = put_byte(scratch_q, nbytes_m1[1:0], ram_din_i);
    assign if_word   = hit_q ? scratch_q : merged;
    assign rd_done   = (state_q == S_DATA_RD) && rd_last;
    assign capture   = ((state_q == S_DATA_RD) || ((state_q == S_IF_RD) && !hit_q))
                       && (cnt_q != 3'd0) && (cnt_q <= nbytes_q);

`ifdef FETCH_BUF_EN
    if_buffer u_if_buffer (
        .clk           (clk),
        .rst           (rst),
        .lookup_addr_i (if_addr_i),
        .hit_o         (buf_hit),
        .word_o        (buf_word),
        .fill_i        (if_done),
        .fill_addr_i   (addr_q),
        .fill_word_i   (if_word),
        .inval_i       (ram_wr),
        .inval_addr_i  (ram_addr)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and RAM/handshake outputs for the current state.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        data_done = 1'b0;
        if_done   = 1'b0;
        ram_addr  = '0;
        ram_dout  = '0;
        ram_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    state_d = mem_write_i ? S_DATA_WR : S_DATA_RD;
                end else if (if_req_i) begin
                    state_d = S_IF_RD;
                end
            end
            S_DATA_RD: begin
                busy      = 1'b1;
                data_done = rd_last;
                if (issue) begin
                    ram_addr = addr_q + {29'd0, cnt_q};
                end
                if (rd_last) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA_WR: begin
                busy      = 1'b1;
                data_done = wr_last;
                ram_wr    = 1'b1;
                ram_addr  = addr_q + {29'd0, cnt_q};
                ram_dout  = get_byte(wdata_q, cnt_q[1:0]);
                if (wr_last) begin
                    state_d = S_IDLE;
                end
            end
            S_IF_RD: begin
                busy = 1'b1;
                if (hit_q) begin
                    if_done = (cnt_q == 3'd0);
                end else begin
                    if_done = rd_last;
                    if (issue) begin
                        ram_addr = addr_q + {29'd0, cnt_q};
                    end
                end
                if (if_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch at acceptance, byte counter, read assembly and result holding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            nbytes_q  <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            data_q    <= '0;
            inst_q    <= '0;
            hit_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
            if (data_req) begin
                addr_q    <= mem_addr_i;
                wdata_q   <= mem_wdata_i;
                nbytes_q  <= type_bytes(mem_type_i);
                scratch_q <= '0;
                hit_q     <= 1'b0;
            end else if (if_req_i) begin
                addr_q    <= if_addr_i;
                nbytes_q  <= FETCH_BYTES;
                scratch_q <= buf_hit ? buf_word : 32'd0;
                hit_q     <= buf_hit;
            end
        end else begin
            cnt_q <= cnt_q + 3'd1;
            if (capture) begin
                scratch_q <= put_byte(scratch_q, cnt_m1[1:0], ram_din_i);
            end
            if (rd_done) begin
                data_q <= merged;
            end
            if (if_done) begin
                inst_q <= if_word;
            end
        end
    end

    assign busy_o      = busy;
    assign data_done_o = data_done;
    assign if_done_o   = if_done;
    assign ram_addr_o  = ram_addr;
    assign ram_dout_o  = ram_dout;
    assign ram_wr_o    = ram_wr;
    assign mem_data_o  = rd_done ? merged : data_q;
    assign if_inst_o   = if_done ? if_word : inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model (one-cycle read
// latency). Honours FETCH_BUF_EN for the fetch-buffer expectations.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [1:0]  mem_type = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_data;
    logic        busy;
    logic        data_done;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_inst;
    logic        if_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din = '0;

    logic [7:0]  ram_mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int          wr_count = 0;

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_type_i  (mem_type),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .mem_data_o  (mem_data),
        .busy_o      (busy),
        .data_done_o (data_done),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_inst_o   (if_inst),
        .if_done_o   (if_done),
        .ram_addr_o  (ram_addr),
        .ram_dout_o  (ram_dout),
        .ram_wr_o    (ram_wr),
        .ram_din_i   (ram_din)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, byte write, backdoor preload port.
    always @(posedge clk) begin
        ram_din <= ram_mem[ram_addr[9:0]];
        if (pl_en) begin
            ram_mem[pl_addr] <= pl_data;
        end else if (ram_wr) begin
            ram_mem[ram_addr[9:0]] <= ram_dout;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Waits for data_done after inputs were presented; latency counted in cycles.
    task automatic wait_data(output int lat, output logic [31:0] rdata);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            mem_read = 1'b0; mem_write = 1'b0; mem_type = 2'd0;
        end while (!data_done && lat < 20);
        rdata = mem_data;
        if (!data_done) lat = 99;
    endtask

    task automatic data_txn(input logic wr, input logic [1:0] ty, input logic [31:0] a,
                            input logic [31:0] wd, output int lat, output logic [31:0] rdata);
        @(negedge clk);
        mem_read = !wr; mem_write = wr; mem_type = ty; mem_addr = a; mem_wdata = wd;
        wait_data(lat, rdata);
        $display("txn %s ty=%0d addr=%08h wdata=%08h lat=%0d rdata=%08h",
                 wr ? "ST" : "LD", ty, a, wd, lat, rdata);
    endtask

    task automatic fetch_txn(input logic [31:0] a, output int lat, output logic [31:0] inst);
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if_req = 1'b0;
        end while (!if_done && lat < 20);
        inst = if_inst;
        if (!if_done) lat = 99;
        $display("txn IF addr=%08h lat=%0d inst=%08h", a, lat, inst);
    endtask

    logic [9:0] pre_a [0:20];
    logic [7:0] pre_d [0:20];

    initial begin
        int lat, dlat, flat, cyc, wc0, exp_hit_lat;
        logic [31:0] rd, inst, dval;
        logic busy_c3;

        pre_a = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h010, 10'h000, 10'h001,
                  10'h002, 10'h003, 10'h040, 10'h041, 10'h042, 10'h043, 10'h200,
                  10'h201, 10'h202, 10'h203, 10'h300, 10'h301, 10'h302, 10'h303};
        pre_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h13, 8'h57,
                  8'h9B, 8'hDF, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 21; i++) poke(pre_a[i], pre_d[i]);

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LW 0x100
        data_txn(1'b0, 2'd3, 32'h100, 32'd0, lat, rd);
        chk("lw_lat", lat, 32'd5);
        chk("lw_data", rd, 32'h44332211);
        @(negedge clk);
        chk("lw_idle", {31'd0, busy}, 32'd0);
        chk("lw_hold", mem_data, 32'h44332211);

        // LB / LH with zero extension
        data_txn(1'b0, 2'd1, 32'h102, 32'd0, lat, rd);
        chk("lb_lat", lat, 32'd2);
        chk("lb_data", rd, 32'h00000033);
        data_txn(1'b0, 2'd2, 32'h101, 32'd0, lat, rd);
        chk("lh_lat", lat, 32'd3);
        chk("lh_data", rd, 32'h00003322);

        // SH unaligned
        wc0 = wr_count;
        data_txn(1'b1, 2'd2, 32'h201, 32'hDEADBEEF, lat, rd);
        chk("sh_lat", lat, 32'd2);
        @(negedge clk);
        chk("sh_wr_count", wr_count - wc0, 32'd2);
        chk("sh_b200", {24'd0, ram_mem[10'h200]}, 32'h00);
        chk("sh_b201", {24'd0, ram_mem[10'h201]}, 32'hEF);
        chk("sh_b202", {24'd0, ram_mem[10'h202]}, 32'hBE);
        chk("sh_b203", {24'd0, ram_mem[10'h203]}, 32'h00);

        // Simultaneous LB and fetch: data first, fetch in the next IDLE cycle
        @(negedge clk);
        mem_read = 1'b1; mem_type = 2'd1; mem_addr = 32'h10; if_req = 1'b1; if_addr = 32'h0;
        cyc = 0; dlat = 0; flat = 0; dval = '0; inst = '0; busy_c3 = 1'b1;
        while ((dlat == 0 || flat == 0) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            mem_read = 1'b0; mem_type = 2'd0;
            if (cyc == 3) busy_c3 = busy;
            if (data_done) begin dlat = cyc; dval = mem_data; end
            if (if_done) begin flat = cyc; inst = if_inst; if_req = 1'b0; end
        end
        if_req = 1'b0;
        $display("txn LB+IF dlat=%0d data=%08h flat=%0d inst=%08h", dlat, dval, flat, inst);
        chk("sim_lb_lat", dlat, 32'd2);
        chk("sim_lb_data", dval, 32'h0000005A);
        chk("sim_gap_idle", {31'd0, busy_c3}, 32'd0);
        chk("sim_if_lat", flat, 32'd8);
        chk("sim_if_inst", inst, 32'hDF9B5713);

        // Fetch buffer behaviour (full RAM timing when the buffer is absent)
`ifdef FETCH_BUF_EN
        exp_hit_lat = 1;
`else
        exp_hit_lat = 5;
`endif
        fetch_txn(32'h40, lat, inst);
        chk("if40_lat", lat, 32'd5);
        chk("if40_inst", inst, 32'hD4C3B2A1);
        fetch_txn(32'h40, lat, inst);
        chk("if40_again_lat", lat, exp_hit_lat);
        chk("if40_again_inst", inst, 32'hD4C3B2A1);
        data_txn(1'b1, 2'd1, 32'h42, 32'h00000077, lat, rd);
        chk("sb_lat", lat, 32'd1);
        fetch_txn(32'h40, lat, inst);
        chk("if40_inval_lat", lat, 32'd5);
        chk("if40_inval_inst", inst, 32'hD477B2A1);

        // Reset in the middle of SW, with byte 2 in flight
        @(negedge clk);
        mem_write = 1'b1; mem_type = 2'd3; mem_addr = 32'h300; mem_wdata = 32'h01020304;
        @(negedge clk);
        mem_write = 1'b0; mem_type = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("sw_wr_before", {31'd0, ram_wr}, 32'd1);
        chk("sw_addr_before", ram_addr, 32'h302);
        rst = 1'b0;
        #1;
        chk("sw_rst_wr", {31'd0, ram_wr}, 32'd0);
        chk("sw_rst_busy", {31'd0, busy}, 32'd0);
        chk("sw_rst_addr", ram_addr, 32'd0);
        chk("sw_rst_dout", {24'd0, ram_dout}, 32'd0);
        chk("sw_rst_mem_data", mem_data, 32'd0);
        chk("sw_rst_if_inst", if_inst, 32'd0);
        chk("sw_rst_done", {30'd0, data_done, if_done}, 32'd0);
        @(negedge clk);
        chk("sw_b300", {24'd0, ram_mem[10'h300]}, 32'h04);
        chk("sw_b301", {24'd0, ram_mem[10'h301]}, 32'h03);
        chk("sw_b302", {24'd0, ram_mem[10'h302]}, 32'h00);
        chk("sw_b303", {24'd0, ram_mem[10'h303]}, 32'h00);
        $display("txn SW 00000300 reset after byte 1");

        // Request accepted in the first cycle after reset release
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b1; mem_type = 2'd1; mem_addr = 32'h100;
        wait_data(lat, rd);
        $display("txn LD after reset addr=00000100 lat=%0d rdata=%08h", lat, rd);
        chk("post_rst_lat", lat, 32'd2);
        chk("post_rst_data", rd, 32'h00000011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports from mem stage: mem_addr_i in 32 byte address; mem_wdata_i in 32 store data; mem_type_i in 2 (No_mem_type/b/h/w); mem_read_i in 1; mem_write_i in 1.
REQ-004 SHALL have ports to mem stage: mem_data_o out 32 zero-extended load data; busy_o out 1 stall request; data_done_o out 1 one-cycle completion pulse.
REQ-005 SHALL have fetch port: if_req_i in 1; if_addr_i in 32; if_inst_o out 32; if_done_o out 1 one-cycle pulse.
REQ-006 SHALL have RAM port: ram_addr_o out 32; ram_dout_o out 8; ram_wr_o out 1 (1=write); ram_din_i in 8, valid one cycle after its address.

Function
REQ-007 SHALL use FSM states IDLE, DATA_RD, DATA_WR, IF_RD; busy_o = (state != IDLE).
REQ-008 SHALL accept a request only in IDLE; data request (mem_read_i|mem_write_i, mem_type_i != No_mem_type) beats if_req_i in the same cycle.
REQ-009 SHALL latch address, wdata, byte count N (b=1, h=2, w=4, fetch=4) at acceptance; inputs ignored afterwards.
REQ-010 SHALL drive byte k (k=0..N-1) at ram_addr_o = addr+k (32-bit wrap), one byte per cycle, starting the cycle after acceptance; no alignment check.
REQ-011 SHALL write little-endian: ram_dout_o = wdata[8k+7:8k], ram_wr_o=1 only during the N write cycles.
REQ-012 SHALL capture ram_din_i into byte k of a result register one cycle after address k; unread bytes zero.
REQ-013 SHALL pulse data_done_o/if_done_o in the final busy cycle: read at acceptance+N+1 cycles, write at acceptance+N cycles; return to IDLE next cycle.
REQ-014 SHALL hold mem_data_o/if_inst_o stable from done until the next completion of the same port.
REQ-015 SHALL never abort an in-progress access; a data request arriving during IF_RD waits for IDLE.
REQ-016 SHALL drive ram_wr_o=0, ram_addr_o=0, ram_dout_o=0 in IDLE.

Reset
REQ-017 SHALL on rst=0 immediately force state IDLE, all outputs 0, result registers 0; an interrupted write stops at the byte in flight.
REQ-018 SHALL accept a request in the first cycle after rst deasserts.

Configuration
REQ-019 SHALL, with FETCH_BUF_EN defined, keep a one-entry fetch buffer (tag, word, valid); fetch hit pulses if_done_o the cycle after acceptance with no RAM access.
REQ-020 SHALL, with FETCH_BUF_EN, fill the buffer on every fetch completion and clear valid on any data write overlapping the tagged word.
REQ-021 SHALL, without FETCH_BUF_EN, have no buffer and every fetch take REQ-013 timing.

Structure
REQ-022 SHALL take memwType encodings and FSM state encodings from the shared config.vh.
REQ-023 SHALL place the fetch buffer in sub-module if_buffer, instantiated only under FETCH_BUF_EN.

Verification
REQ-024 SHALL check: LW addr 0x100, RAM bytes 11,22,33,44 -> mem_data_o=0x44332211, data_done_o 5 cycles after acceptance.
REQ-025 SHALL check: SH addr 0x201, wdata 0xDEADBEEF -> writes EF@0x201, BE@0x202, no third write, done 2 cycles after acceptance.
REQ-026 SHALL check: simultaneous LB 0x10 and fetch 0x0 -> LB served first, fetch accepted in following IDLE cycle.
REQ-027 SHALL check: rst=0 mid-SW after byte 1 -> ram_wr_o drops same cycle, busy_o=0, outputs 0.
REQ-028 SHALL check (FETCH_BUF_EN): fetch 0x40 twice -> second done after 1 cycle; SB 0x42 then fetch 0x40 -> full 5-cycle RAM fetch.
